// File: rtl/rv_rrsel.sv
// rtl/rv_rrsel.sv - registered round-robin/fixed priority selector with valid/ready output.
// Define RV_RRSEL_GNT_EN to add the registered one-hot grant port dout_gnt.
module rv_rrsel #(
  parameter int q_num_entries_g = 16,
  parameter int q_dat_width_g   = 7,
  parameter int q_idx_width_g   = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       rr_mode,
  input  logic [q_num_entries_g-1:0]                 cond,
  input  logic [q_dat_width_g*q_num_entries_g-1:0]   din,
  input  logic                                       dout_ready,
  output logic                                       dout_val,
  output logic [q_dat_width_g-1:0]                   dout,
  output logic [q_idx_width_g-1:0]                   dout_idx
`ifdef RV_RRSEL_GNT_EN
  ,
  output logic [q_num_entries_g-1:0]                 dout_gnt
`endif
);

  localparam int N  = q_num_entries_g;
  localparam int W  = q_dat_width_g;
  localparam int IW = q_idx_width_g;
  localparam int P  = 1 << IW;

  typedef struct packed {
    logic          hit;
    logic [IW-1:0] idx;
  } sel_t;

  // Highest-index-wins reduction over a power-of-two padded vector, log2(P) levels deep.
  function automatic sel_t hi_sel(input logic [N-1:0] v);
    logic [P-1:0]  hit;
    logic [IW-1:0] idx [P];
    sel_t          res;
    hit        = '0;
    hit[N-1:0] = v;
    for (int j = 0; j < P; j++) idx[j] = IW'(j);
    for (int s = 1; s < P; s = s * 2) begin
      for (int j = 0; j + s < P; j = j + 2 * s) begin
        if (hit[j+s]) begin
          hit[j] = 1'b1;
          idx[j] = idx[j+s];
        end
      end
    end
    res.hit = hit[0];
    res.idx = idx[0];
    return res;
  endfunction

  logic [IW-1:0] ptr;
  logic [N-1:0]  below_ptr;
  sel_t          sel_all;
  sel_t          sel_msk;
  sel_t          win;
  logic          load;

  always_comb begin
    below_ptr = '0;
    for (int i = 0; i < N; i++) below_ptr[i] = (i < int'(ptr));
  end

  // Entries below the last winner go first; otherwise fall back to the whole vector.
  assign sel_all = hi_sel(cond);
  assign sel_msk = hi_sel(cond & below_ptr);
  assign win     = (rr_mode && sel_msk.hit) ? sel_msk : sel_all;
  assign load    = ~dout_val | dout_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_val <= 1'b0;
      dout     <= '0;
      dout_idx <= '0;
      ptr      <= '0;
    end else if (load) begin
      if (win.hit) begin
        dout_val <= 1'b1;
        dout     <= din[int'(win.idx)*W +: W];
        dout_idx <= win.idx;
        ptr      <= rr_mode ? win.idx : '0;
      end else begin
        dout_val <= 1'b0;
        dout     <= '0;
        dout_idx <= '0;
      end
    end
  end

`ifdef RV_RRSEL_GNT_EN
  logic [N-1:0] gnt_next;

  always_comb begin
    gnt_next = '0;
    if (win.hit) gnt_next[win.idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)       dout_gnt <= '0;
    else if (load) dout_gnt <= gnt_next;
  end
`else
  // Grant vector not built; index reporting only.
`endif

endmodule

// File: tb/tb_rv_rrsel.sv
// tb/tb_rv_rrsel.sv - directed and randomized checks of rv_rrsel against a search-order model.
module tb_rv_rrsel;

  localparam int NA = 16;
  localparam int NB = 12;
  localparam int W  = 7;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_a, rr_a, ready_a, val_a;
  logic [NA-1:0]   cond_a;
  logic [NA*W-1:0] din_a;
  logic [W-1:0]    dout_a;
  logic [IW-1:0]   idx_a;

  logic            rst_b, rr_b, ready_b, val_b;
  logic [NB-1:0]   cond_b;
  logic [NB*W-1:0] din_b;
  logic [W-1:0]    dout_b;
  logic [IW-1:0]   idx_b;

`ifdef RV_RRSEL_GNT_EN
  logic [NA-1:0] gnt_a;
  logic [NB-1:0] gnt_b;
`endif

  rv_rrsel #(.q_num_entries_g(NA), .q_dat_width_g(W), .q_idx_width_g(IW)) dut_a (
    .clk(clk), .rst(rst_a), .rr_mode(rr_a), .cond(cond_a), .din(din_a),
    .dout_ready(ready_a), .dout_val(val_a), .dout(dout_a), .dout_idx(idx_a)
`ifdef RV_RRSEL_GNT_EN
    , .dout_gnt(gnt_a)
`endif
  );

  rv_rrsel #(.q_num_entries_g(NB), .q_dat_width_g(W), .q_idx_width_g(IW)) dut_b (
    .clk(clk), .rst(rst_b), .rr_mode(rr_b), .cond(cond_b), .din(din_b),
    .dout_ready(ready_b), .dout_val(val_b), .dout(dout_b), .dout_idx(idx_b)
`ifdef RV_RRSEL_GNT_EN
    , .dout_gnt(gnt_b)
`endif
  );

  int checks = 0;
  int errors = 0;
  int ma_val, ma_dout, ma_idx, ma_ptr;
  int mb_val, mb_dout, mb_idx, mb_ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walk the search order ptr-1, ptr-2, ... modulo n; fixed mode is the ptr=0 walk.
  function automatic int pick(input int n, input int p, input logic [63:0] c, input logic rr);
    int q;
    q = rr ? p : 0;
    for (int k = 1; k <= n; k++) begin
      int i;
      i = (q - k + n) % n;
      if (c[i]) return i;
    end
    return -1;
  endfunction

  task automatic cyc_a(input logic r, input logic rr, input logic [NA-1:0] c, input logic rdy);
    int w;
    rst_a = r; rr_a = rr; cond_a = c; ready_a = rdy;
    @(posedge clk);
    if (r) begin
      ma_val = 0; ma_dout = 0; ma_idx = 0; ma_ptr = 0;
    end else if (ma_val == 0 || rdy) begin
      w = pick(NA, ma_ptr, 64'(c), rr);
      if (w < 0) begin
        ma_val = 0; ma_dout = 0; ma_idx = 0;
      end else begin
        ma_val = 1; ma_idx = w; ma_dout = int'(din_a[w*W +: W]); ma_ptr = rr ? w : 0;
      end
    end
    #1;
    chk("a_val", 64'(val_a), 64'(ma_val));
    chk("a_dout", 64'(dout_a), 64'(ma_dout));
    chk("a_idx", 64'(idx_a), 64'(ma_idx));
`ifdef RV_RRSEL_GNT_EN
    chk("a_gnt", 64'(gnt_a), ma_val != 0 ? (64'd1 << ma_idx) : 64'd0);
`endif
  endtask

  task automatic cyc_b(input logic r, input logic rr, input logic [NB-1:0] c, input logic rdy);
    int w;
    rst_b = r; rr_b = rr; cond_b = c; ready_b = rdy;
    @(posedge clk);
    if (r) begin
      mb_val = 0; mb_dout = 0; mb_idx = 0; mb_ptr = 0;
    end else if (mb_val == 0 || rdy) begin
      w = pick(NB, mb_ptr, 64'(c), rr);
      if (w < 0) begin
        mb_val = 0; mb_dout = 0; mb_idx = 0;
      end else begin
        mb_val = 1; mb_idx = w; mb_dout = int'(din_b[w*W +: W]); mb_ptr = rr ? w : 0;
      end
    end
    #1;
    chk("b_val", 64'(val_b), 64'(mb_val));
    chk("b_dout", 64'(dout_b), 64'(mb_dout));
    chk("b_idx", 64'(idx_b), 64'(mb_idx));
    chk("b_idx_range", 64'(idx_b < 4'd12), 64'd1);
`ifdef RV_RRSEL_GNT_EN
    chk("b_gnt", 64'(gnt_b), mb_val != 0 ? (64'd1 << mb_idx) : 64'd0);
`endif
  endtask

  initial begin
    logic [NA-1:0] ra;
    logic [NB-1:0] rb;
    int sel;

    for (int i = 0; i < NA; i++) din_a[i*W +: W] = W'(i + 16);
    for (int i = 0; i < NB; i++) din_b[i*W +: W] = W'(i + 16);
    rst_b = 1'b1; rr_b = 1'b0; cond_b = '0; ready_b = 1'b1;

    cyc_a(1'b1, 1'b0, '0, 1'b1);
    chk("reset_val", 64'(val_a), 64'd0);
    chk("reset_idx", 64'(idx_a), 64'd0);

    cyc_a(1'b0, 1'b0, 16'h0208, 1'b1);
    chk("fixed_dout", 64'(dout_a), 64'h19);
    chk("fixed_idx", 64'(idx_a), 64'd9);
    cyc_a(1'b0, 1'b1, '1, 1'b1);
    chk("fixed_ptr_zero", 64'(idx_a), 64'd15);

    cyc_a(1'b1, 1'b1, '1, 1'b1);
    for (int k = 0; k < 17; k++) begin
      cyc_a(1'b0, 1'b1, '1, 1'b1);
      chk("rr_rotate_idx", 64'(idx_a), 64'((31 - k) % 16));
      chk("rr_rotate_val", 64'(val_a), 64'd1);
    end

    cyc_a(1'b0, 1'b0, 16'h0020, 1'b1);
    chk("stall_pre_idx", 64'(idx_a), 64'd5);
    for (int k = 0; k < 3; k++) begin
      cyc_a(1'b0, 1'b0, 16'h1000, 1'b0);
      chk("stall_dout", 64'(dout_a), 64'h15);
      chk("stall_idx", 64'(idx_a), 64'd5);
    end
    cyc_a(1'b0, 1'b0, 16'h1000, 1'b1);
    chk("stall_release_idx", 64'(idx_a), 64'd12);

    cyc_a(1'b0, 1'b1, 16'h0080, 1'b1);
    chk("midrst_pre_idx", 64'(idx_a), 64'd7);
    cyc_a(1'b0, 1'b1, '1, 1'b0);
    cyc_a(1'b1, 1'b1, '1, 1'b0);
    chk("midrst_val", 64'(val_a), 64'd0);
    chk("midrst_dout", 64'(dout_a), 64'd0);
    cyc_a(1'b0, 1'b1, '1, 1'b1);
    chk("midrst_after_idx", 64'(idx_a), 64'd15);

`ifdef RV_RRSEL_GNT_EN
    cyc_a(1'b0, 1'b0, 16'h0010, 1'b1);
    chk("gnt_onehot", 64'(gnt_a), 64'h10);
    cyc_a(1'b0, 1'b0, '0, 1'b1);
    chk("gnt_empty", 64'(gnt_a), 64'd0);
`endif

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NA; i++) din_a[i*W +: W] = W'($urandom);
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      ra = '0;
      else if (sel == 1) ra = NA'(1) << $urandom_range(0, NA - 1);
      else               ra = NA'($urandom);
      cyc_a(($urandom_range(0, 49) == 0), 1'($urandom), ra, ($urandom_range(0, 3) != 0));
    end

    for (int i = 0; i < NB; i++) din_b[i*W +: W] = W'(i + 16);
    cyc_b(1'b1, 1'b1, '0, 1'b1);
    cyc_b(1'b0, 1'b1, '0, 1'b1);
    chk("n12_empty_val", 64'(val_b), 64'd0);
    chk("n12_empty_dout", 64'(dout_b), 64'd0);
    cyc_b(1'b0, 1'b1, 12'h801, 1'b1);
    chk("n12_first_idx", 64'(idx_b), 64'd11);
    cyc_b(1'b0, 1'b1, 12'h801, 1'b1);
    chk("n12_second_idx", 64'(idx_b), 64'd0);
    cyc_b(1'b0, 1'b1, 12'h801, 1'b1);
    chk("n12_wrap_idx", 64'(idx_b), 64'd11);

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NB; i++) din_b[i*W +: W] = W'($urandom);
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      rb = '0;
      else if (sel == 1) rb = NB'(1) << $urandom_range(0, NB - 1);
      else               rb = NB'($urandom);
      cyc_b(($urandom_range(0, 49) == 0), 1'($urandom), rb, ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
